// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe.
// master = operand producer and result consumer; slave = the arithmetic unit.
interface addsub_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cb_in;
    logic             op_sub;
    logic             sgn;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cb_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cb_in, op_sub, sgn, sat, out_ready,
        input  in_ready, out_valid, result, cb_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cb_in, op_sub, sgn, sat, out_ready,
        output in_ready, out_valid, result, cb_out, ovf, zero
    );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit: one WIDTH/STAGES-bit carry segment per stage,
// saturation and flags resolved in the final (output) stage, global-stall handshake.
module addsub_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    addsub_pipe_if.slave     bus,
    output logic             busy
);
    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  r_q   [STAGES];
    logic              c_q   [STAGES];
    logic              sub_q [STAGES];
    logic              sgn_q [STAGES];
    logic              sat_q [STAGES];
    logic              ovf_q;
    logic              zero_q;

    logic [STAGES-1:0] v_d;
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  r_d   [STAGES];
    logic [WIDTH-1:0]  r_n   [STAGES];
    logic              c_d   [STAGES];
    logic              c_n   [STAGES];
    logic              sub_d [STAGES];
    logic              sgn_d [STAGES];
    logic              sat_d [STAGES];
    logic [SEG:0]      seg;

    logic              advance;
    logic [WIDTH-1:0]  raw;
    logic [WIDTH-1:0]  sat_val;
    logic [WIDTH-1:0]  res_n;
    logic              cb_n;
    logic              sovf;
    logic              ovf_n;

    always_comb begin
        advance = !v_q[LAST] || bus.out_ready;

        // Stage 0 sees the operand bus with B and the carry already inverted for subtraction.
        v_d[0]   = bus.in_valid;
        a_d[0]   = bus.a;
        b_d[0]   = bus.op_sub ? ~bus.b : bus.b;
        r_d[0]   = '0;
        c_d[0]   = bus.op_sub ? ~bus.cb_in : bus.cb_in;
        sub_d[0] = bus.op_sub;
        sgn_d[0] = bus.sgn;
        sat_d[0] = bus.sat;
        for (int unsigned k = 1; k < STAGES; k++) begin
            v_d[k]   = v_q[k-1];
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            r_d[k]   = r_q[k-1];
            c_d[k]   = c_q[k-1];
            sub_d[k] = sub_q[k-1];
            sgn_d[k] = sgn_q[k-1];
            sat_d[k] = sat_q[k-1];
        end

        seg = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            seg = {1'b0, a_d[k][k*SEG +: SEG]} + {1'b0, b_d[k][k*SEG +: SEG]}
                + {{SEG{1'b0}}, c_d[k]};
            r_n[k] = r_d[k];
            r_n[k][k*SEG +: SEG] = seg[SEG-1:0];
            c_n[k] = seg[SEG];
        end

        raw  = r_n[LAST];
        cb_n = sub_d[LAST] ? ~c_n[LAST] : c_n[LAST];
        sovf = (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1])
            && (raw[WIDTH-1] != a_d[LAST][WIDTH-1]);
        ovf_n = sgn_d[LAST] ? sovf : cb_n;

        if (sgn_d[LAST])
            sat_val = a_d[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            sat_val = sub_d[LAST] ? '0 : '1;
        res_n = (sat_d[LAST] && ovf_n) ? sat_val : raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                r_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
                sgn_q[k] <= 1'b0;
                sat_q[k] <= 1'b0;
            end
        end else if (advance) begin
            v_q <= v_d;
            // Bubbles leave stage data untouched so the outputs hold the last result.
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (v_d[k]) begin
                    a_q[k]   <= a_d[k];
                    b_q[k]   <= b_d[k];
                    r_q[k]   <= r_n[k];
                    c_q[k]   <= c_n[k];
                    sub_q[k] <= sub_d[k];
                    sgn_q[k] <= sgn_d[k];
                    sat_q[k] <= sat_d[k];
                end
            end
            if (v_d[LAST]) begin
                r_q[LAST] <= res_n;
                c_q[LAST] <= cb_n;
                ovf_q     <= ovf_n;
                zero_q    <= (res_n == '0);
            end
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = v_q[LAST];
    assign bus.result    = r_q[LAST];
    assign bus.cb_out    = c_q[LAST];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign busy          = |v_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// Randomised and directed bench for addsub_pipe against an arithmetic reference
// model with a STAGES-deep latency pipe and global stall.
module tb_addsub_pipe;
    localparam int unsigned W = 16;
    localparam int unsigned S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    addsub_pipe_if #(.WIDTH(W)) bus ();

    addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         v;
        logic [W-1:0] res;
        logic         cb;
        logic         ovf;
    } beat_t;

    beat_t pipe [S];
    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] pool [8] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000,
                               16'hFFFF, 16'h00FF, 16'h0100, 16'hFF00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Exact integer arithmetic; flags and saturation follow from range checks.
    function automatic beat_t ref_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c, input logic sub, input logic sg,
                                       input logic st, input logic v);
        beat_t r;
        longint ua, ub, sa, sb, ci, u, s, lim, maxs, mins;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ci   = longint'(c);
        lim  = longint'(1) <<< W;
        maxs = (lim >>> 1) - 1;
        mins = -(lim >>> 1);
        u    = sub ? ua - ub - ci : ua + ub + ci;
        s    = sub ? sa - sb - ci : sa + sb + ci;
        r.v   = v;
        r.cb  = sub ? (u < 0) : (u >= lim);
        r.res = u[W-1:0];
        r.ovf = sg ? (s > maxs || s < mins) : r.cb;
        if (st && r.ovf) begin
            if (sg) r.res = (s > maxs) ? maxs[W-1:0] : mins[W-1:0];
            else    r.res = sub ? '0 : '1;
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < int'(S); k++) pipe[k] = '0;
    endtask

    // Called at posedge+1 with inputs set; checks, advances one clock, returns at posedge+1.
    task automatic step(output logic acc);
        logic  ready_exp;
        logic  busy_exp;
        beat_t h, nb;
        #1;
        h = pipe[S-1];
        ready_exp = !h.v || bus.out_ready;
        busy_exp = 1'b0;
        for (int k = 0; k < int'(S); k++) busy_exp = busy_exp | pipe[k].v;
        check("out_valid", bus.out_valid, h.v);
        check("in_ready", bus.in_ready, ready_exp);
        check("busy", busy, busy_exp);
        if (h.v) begin
            check("result", bus.result, h.res);
            check("cb_out", bus.cb_out, h.cb);
            check("ovf", bus.ovf, h.ovf);
            check("zero", bus.zero, h.res == '0);
        end
        acc = bus.in_valid && ready_exp;
        nb = ref_beat(bus.a, bus.b, bus.cb_in, bus.op_sub, bus.sgn, bus.sat, acc);
        @(posedge clk);
        if (ready_exp) begin
            for (int k = int'(S) - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = nb;
        end
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic sub, input logic sg, input logic st);
        logic acc;
        acc = 1'b0;
        bus.a = a; bus.b = b; bus.cb_in = c;
        bus.op_sub = sub; bus.sgn = sg; bus.sat = st;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(acc);
            if (acc) break;
        end
        check("accept_timeout", acc, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic acc;
        int   cnt;
        clear_model();
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cb_in = 1'b0;
        bus.op_sub = 1'b0; bus.sgn = 1'b0; bus.sat = 1'b0; bus.out_ready = 1'b1;

        #12;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_result", bus.result, '0);
        check("rst_cb_out", bus.cb_out, 1'b0);
        check("rst_ovf", bus.ovf, 1'b0);
        check("rst_zero", bus.zero, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_in_ready", bus.in_ready, 1'b1);

        // 5-3 unsigned, with explicit latency measurement
        send(16'd5, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        cnt = 1;
        while (!bus.out_valid && cnt < 10) begin
            step(acc);
            cnt++;
        end
        check("latency", cnt, S);
        idle(3);

        send(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        send(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1);
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        send(16'h0100, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(4);

        // Backpressure: four back-to-back beats, then a 3-cycle stall with a fifth waiting
        for (int i = 0; i < 4; i++)
            send(16'h1234 * 16'(i + 1), 16'h0F0F + 16'(i), 1'(i), 1'(i >> 1), 1'b0, 1'b0);
        bus.a = 16'h8001; bus.b = 16'h0002; bus.cb_in = 1'b1;
        bus.op_sub = 1'b1; bus.sgn = 1'b1; bus.sat = 1'b1; bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(acc);
        bus.out_ready = 1'b1;
        send(16'h8001, 16'h0002, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(5);

        // Reset with two beats in flight
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
        send(16'h3333, 16'h0444, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_result", bus.result, '0);
        clear_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(16'h0042, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(4);

        // Random traffic with random backpressure, biased to boundary operands
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.a      = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 7)] : W'($urandom);
            bus.b      = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 7)] : W'($urandom);
            bus.cb_in  = 1'($urandom);
            bus.op_sub = 1'($urandom);
            bus.sgn    = 1'($urandom);
            bus.sat    = 1'($urandom);
            step(acc);
        end
        bus.out_ready = 1'b1;
        idle(S + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined add/subtract unit. Successor to the fixed 16-bit combinational subtractor.
- Adds the following over that block:
  - configurable width and pipeline depth, with the carry chain split into per-stage segments;
  - add/sub mode;
  - signed/unsigned saturation;
  - status flags;
  - valid/ready handshake with backpressure.
- Sits between operand fetch and ALU result mux.
- Exposes a busy indication the clock-gating controller uses to gate the datapath when idle.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be divisible by STAGES.
- STAGES, 2, pipeline stages (1..4). Each stage computes one WIDTH/STAGES-bit carry segment.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cb_in  input  1  carry-in (add) or borrow-in (sub).
- op_sub  input  1  0 = A+B+cin; 1 = A-B-bin.
- sgn  input  1  1 = operands two's-complement, 0 = unsigned.
- sat  input  1  1 = saturate on overflow.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference, after saturation.
- cb_out  output  1  carry-out (add) or borrow-out (sub), unsaturated.
- ovf  output  1  overflow per sgn (see Behaviour).
- zero  output  1  result == 0, after saturation.
- busy  output  1  any pipeline stage holds a valid beat.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset:
  - All stage valid bits, data and carry registers cleared immediately.
  - out_valid=0, result=0, cb_out=0, ovf=0, zero=0, busy=0.
  - in_ready=1 after reset deasserts.
  - A beat in flight when reset asserts is discarded; no partial result is ever presented.
- Arithmetic:
  - Subtraction is A + ~B + ~bin, with cb_out = ~carry.
  - Addition is A + B + cin, with cb_out = carry.
  - Stage k (0-based) adds segment bits [(k+1)*W/S-1 : k*W/S] using the carry registered from stage k-1. Stage 0 uses the effective carry-in.
  - Operand bits not yet consumed travel with the beat; already-computed result bits are carried forward.
  - op_sub, sgn and sat are captured with the beat.
- Overflow and saturation:
  - ovf when sgn=1: sign(A) == sign(B') and sign(raw) != sign(A), where B' = B for add and ~B for sub.
  - ovf when sgn=0: equals cb_out.
  - sat=1 and ovf=1, signed: result = 0111..1 if sign(A)=0, else 1000..0.
  - sat=1 and ovf=1, unsigned add: result = all ones.
  - sat=1 and ovf=1, unsigned sub: result = 0.
  - sat=0: raw wrap-around result. ovf is still reported.
- Latency and throughput:
  - Exactly STAGES cycles from accepted input to out_valid, when not stalled.
  - Throughput is one beat per cycle.
- Handshake:
  - Global stall: advance = !out_valid | out_ready. in_ready = advance.
  - Input is accepted when in_valid & in_ready. All stages shift on advance. A bubble enters stage 0 when no beat is accepted.
  - While out_valid=1 and out_ready=0, result, flags and all stages hold stable.
  - Simultaneous accept and drain in the same cycle is legal and loses no beat.
- busy is the OR of all stage valid bits. It is combinationally derived from registers, with no input paths.
- Outputs are registered (final stage). No combinational path exists from a, b or cb_in to any output. in_ready depends combinationally on out_ready.

Test Plan:
- WIDTH=16, STAGES=2, sub, sgn=0, 5-3, bin=0 -> result=0x0002, cb_out=0, ovf=0, zero=0; out_valid exactly 2 cycles after accept.
- Unsigned sub 0x0000-0x0001, sat=0 -> 0xFFFF, cb_out=1, ovf=1. Same beat with sat=1 -> 0x0000, zero=1.
- Signed add 0x7FFF+0x0001: sat=1 -> 0x7FFF, ovf=1. sat=0 -> 0x8000, ovf=1. Signed sub 0x8000-0x0001, sat=1 -> 0x8000, ovf=1.
- Segment carry: add 0x00FF+0x0001 -> 0x0100. Sub 0x0100-0x0001 -> 0x00FF. Both cross the 8-bit stage boundary with correct carry/borrow.
- Backpressure: stream 4 beats back-to-back, hold out_ready=0 for 3 cycles -> in_ready=0 during stall, outputs stable, all 4 results delivered in order, busy deasserts 1 cycle after last drain.
- Reset mid-operation: assert rst_n=0 with 2 beats in flight -> out_valid, busy and result go to 0 immediately. After release, the first new beat produces the correct result; neither old beat appears.
